// File: rtl/gate_pkg.sv
// gate_pkg: logic-function mode encoding shared by the gate array pipeline.
package gate_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OR   = 3'd0,
        MODE_AND  = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_NAND = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] m);
        return m <= MODE_XNOR;
    endfunction

endpackage

// File: rtl/gate_reduce_core.sv
// gate_reduce_core: combinational bitwise reduction of NUM_IN operands under a selectable mode.
module gate_reduce_core
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [MODE_W-1:0]       mode,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] or_r, and_r, xor_r;

    always_comb begin
        or_r  = '0;
        and_r = '1;
        xor_r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            or_r  = or_r  | in_data[i*WIDTH +: WIDTH];
            and_r = and_r & in_data[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[i*WIDTH +: WIDTH];
        end
    end

    // Illegal modes fall through to OR.
    always_comb begin
        result = mode == MODE_AND  ? and_r  :
                 mode == MODE_XOR  ? xor_r  :
                 mode == MODE_NOR  ? ~or_r  :
                 mode == MODE_NAND ? ~and_r :
                 mode == MODE_XNOR ? ~xor_r : or_r;
    end

    assign err = !is_legal_mode(mode);

endmodule

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: registered NUM_IN-operand logic gate with valid/ready on both sides.
// Define STICKY_ACC_EN to add the acc_clr/acc_data sticky OR accumulator of handed-off results.
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MODE_W-1:0]       in_mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_err
`ifdef STICKY_ACC_EN
    ,
    input  logic                    acc_clr,
    output logic [WIDTH-1:0]        acc_data
`endif
);

    logic [WIDTH-1:0] res;
    logic             res_err;
    logic             accept;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    gate_reduce_core #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_core (
        .in_data(in_data),
        .mode   (in_mode),
        .result (res),
        .err    (res_err)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = accept || (valid_q && !out_ready);
        data_d  = accept ? res : data_q;
        zero_d  = accept ? (res == '0) : zero_q;
        err_d   = accept ? res_err : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;
    assign out_err   = err_q;

`ifdef STICKY_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    // Clear takes priority over a handoff on the same edge.
    always_comb begin
        acc_d = acc_clr ? '0 : (valid_q && out_ready) ? (acc_q | data_q) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_data = acc_q;
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb_gate_array_pipe: randomized scoreboard bench for gate_array_pipe against a per-bit counting model.
module tb_gate_array_pipe;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;
    localparam int DW     = NUM_IN * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             z;
        logic             e;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_mode = 3'd0;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_err;
    logic             acc_clr = 1'b0;
`ifdef STICKY_ACC_EN
    logic [WIDTH-1:0] acc_data;
`endif

    exp_t             q[$];
    logic             mvalid = 1'b0;
    logic [WIDTH-1:0] acc_m = '0;
    int               total = 0;
    int               bad = 0;

    gate_array_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_zero (out_zero),
        .out_err  (out_err)
`ifdef STICKY_ACC_EN
        ,
        .acc_clr  (acc_clr),
        .acc_data (acc_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per bit: count the ones; OR = any, AND = all, XOR = odd count.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [2:0] mode);
        exp_t r;
        int   cnt;
        int   m;
        logic b;
        m = (mode > 3'd5) ? 0 : int'(mode);
        for (int k = 0; k < WIDTH; k++) begin
            cnt = 0;
            for (int i = 0; i < NUM_IN; i++) cnt += int'(d[i*WIDTH + k]);
            case (m % 3)
                0:       b = cnt > 0;
                1:       b = cnt == NUM_IN;
                default: b = (cnt % 2) == 1;
            endcase
            r.d[k] = (m >= 3) ? !b : b;
        end
        r.z = (r.d == '0);
        r.e = (mode > 3'd5);
        return r;
    endfunction

    function automatic logic [DW-1:0] pack(input logic [7:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    task automatic cyc(input logic v, input logic [2:0] m, input logic [DW-1:0] d,
                       input logic ordy, input logic clr, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        acc_clr   = clr;
        @(posedge clk);
        acc = v && (!mvalid || ordy);
        if (acc) q.push_back(model(d, m));
        mvalid = acc || (mvalid && !ordy);
    endtask

    task automatic send(input logic [2:0] m, input logic [DW-1:0] d);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 20 && !a; t++) cyc(1'b1, m, d, 1'b1, 1'b0, a);
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input logic ordy, input logic clr);
        logic a;
        cyc(1'b0, 3'd0, '0, ordy, clr, a);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        repeat (n) @(posedge clk);
        q.delete();
        mvalid = 1'b0;
        acc_m  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: checks every cycle between edges, pops on the cycle a handoff is due.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
                if (q.size() != 0) begin
                    chk("out_data", 32'(out_data), 32'(q[0].d));
                    chk("out_zero", 32'(out_zero), 32'(q[0].z));
                    chk("out_err", 32'(out_err), 32'(q[0].e));
                end
`ifdef STICKY_ACC_EN
                chk("acc_data", 32'(acc_data), 32'(acc_m));
                acc_m = acc_clr ? '0 : (q.size() != 0 && out_ready) ? (acc_m | q[0].d) : acc_m;
`endif
                if (q.size() != 0 && out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic a;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(3'b000, pack(8'h01, 8'h02, 8'h04, 8'h08));
        send(3'b001, pack(8'h01, 8'h02, 8'h04, 8'h08));
        send(3'b010, pack(8'h01, 8'h02, 8'h04, 8'h08));
        send(3'b011, pack(8'h01, 8'h02, 8'h04, 8'h08));
        send(3'b100, pack(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        send(3'b101, pack(8'h0F, 8'h33, 8'h55, 8'h00));
        send(3'b110, pack(8'h10, 8'h00, 8'h00, 8'h00));
        send(3'b111, pack(8'h00, 8'h00, 8'h00, 8'h00));
        idle(1'b1, 1'b0);

        cyc(1'b1, 3'b000, pack(8'hA5, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, a);
        repeat (3) cyc(1'b1, 3'b010, pack(8'h3C, 8'h11, 8'h00, 8'h00), 1'b0, 1'b0, a);
        idle(1'b1, 1'b0);
        send(3'b001, pack(8'hF0, 8'hFF, 8'hF3, 8'hFC));
        idle(1'b1, 1'b0);

        for (int k = 0; k < 8; k++)
            cyc(1'b1, 3'(k % 6), pack(8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)), 1'b1, 1'b0, a);
        idle(1'b1, 1'b0);

        for (int k = 0; k < 300; k++)
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), DW'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a);
        idle(1'b1, 1'b0);

        cyc(1'b1, 3'b000, pack(8'h77, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, a);
        do_reset(1);
        #3;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        send(3'b000, pack(8'h00, 8'h00, 8'h00, 8'h00));
        idle(1'b1, 1'b0);

`ifdef STICKY_ACC_EN
        idle(1'b1, 1'b1);
        send(3'b000, pack(8'h01, 8'h00, 8'h00, 8'h00));
        send(3'b000, pack(8'h80, 8'h00, 8'h00, 8'h00));
        send(3'b000, pack(8'h04, 8'h00, 8'h00, 8'h00));
        idle(1'b1, 1'b0);
        @(negedge clk);
        #3;
        chk("acc_85", 32'(acc_data), 32'h85);
        send(3'b000, pack(8'h02, 8'h00, 8'h00, 8'h00));
        idle(1'b1, 1'b1);
        @(negedge clk);
        #3;
        chk("acc_clr_wins", 32'(acc_data), 32'h00);
`endif

        repeat (2) idle(1'b1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
